// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM and its ALU decoder
package ctrl_pkg;

  // State encoding (4-bit); codes 10..15 are illegal and recover to FETCH
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd field, instr[24:21]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // ALU B operand select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - data-processing decode: ALU op, flag-write enables, no-write and R15 terms
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 2
) (
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  ALUOp,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  NoWrite,
  output logic                  PCSTerm
);

  logic [3:0] cmd;
  logic       s_bit;
  logic [1:0] op_dec;
  logic [1:0] flag_dec;

  assign cmd     = Funct[4:1];
  assign s_bit   = Funct[0];
  assign PCSTerm = (Rd == 4'hF);

  // Decode cmd; NoWrite stays valid outside execute so ALUWB can use it
  always_comb begin
    op_dec   = ALU_ADD;
    flag_dec = 2'b00;
    NoWrite  = 1'b0;
    case (cmd)
      CMD_ADD: begin op_dec = ALU_ADD; flag_dec = {s_bit, s_bit}; end
      CMD_SUB: begin op_dec = ALU_SUB; flag_dec = {s_bit, s_bit}; end
      CMD_AND: begin op_dec = ALU_AND; flag_dec = {s_bit, 1'b0};  end
      CMD_ORR: begin op_dec = ALU_ORR; flag_dec = {s_bit, 1'b0};  end
      // Compare always updates flags and never writes the register file
      CMD_CMP: begin op_dec = ALU_SUB; flag_dec = 2'b11; NoWrite = 1'b1; end
      default: begin op_dec = ALU_ADD; flag_dec = 2'b00; NoWrite = 1'b1; end
    endcase
  end

  // Decoded op and flag enables only apply in the execute states
  always_comb begin
    ALUControl = ALU_CTRL_W'(ALU_ADD);
    FlagW      = 2'b00;
    if (ALUOp) begin
      ALUControl = ALU_CTRL_W'(op_dec);
      FlagW      = flag_dec;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle processor sequencing FSM with Moore outputs
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  output logic                  NextPC,
  output logic                  PCS,
  output logic                  RegW,
  output logic                  MemW,
  output logic [1:0]            FlagW,
  output logic                  Branch,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [3:0]            StateDbg
);

  state_t state_q, state_d;
  logic   alu_op;
  logic   no_write;
  logic   pcs_term;

  assign alu_op   = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign StateDbg = state_q;
  assign ImmSrc   = Op;
  assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
  assign PCS      = Branch | (RegW & pcs_term);

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUOp      (alu_op),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .NoWrite    (no_write),
    .PCSTerm    (pcs_term)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing from the decoded instruction class
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore datapath controls per state
  always_comb begin
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTEI: ALUSrcB = SRCB_IMM;
      S_ALUWB:    RegW    = ~no_write;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       NextPC, PCS, RegW, MemW, Branch, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0] StateDbg;

  int checks;
  int errors;

  multicycle_control_fsm #(.ALU_CTRL_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .NextPC     (NextPC),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .FlagW      (FlagW),
    .Branch     (Branch),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .StateDbg   (StateDbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one cycle, landing on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // short async reset pulse between edges; leaves the FSM in FETCH
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (StateDbg !== 4'd0) begin errors++; $display("FAIL reset_hold: state %0d expected 0", StateDbg); end
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if (StateDbg !== 4'd3) begin errors++; $display("FAIL reach_memread: state %0d expected 3", StateDbg); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (StateDbg !== 4'd0) begin errors++; $display("FAIL async_reset: state %0d expected 0", StateDbg); end
    checks++;
    if ({RegW, MemW, PCS, FlagW, Branch} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: RegW/MemW/PCS/FlagW/Branch %b expected 000000", {RegW, MemW, PCS, FlagW, Branch});
    end
    @(negedge clk);
    checks++;
    if (StateDbg !== 4'd0) begin errors++; $display("FAIL reset_held_edge: state %0d expected 0", StateDbg); end
    #2;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (StateDbg !== 4'd1) begin errors++; $display("FAIL release_decode: state %0d expected 1", StateDbg); end
  endtask

  task automatic test_ldr();
    logic [3:0] exp_st [6];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (StateDbg !== exp_st[i]) begin errors++; $display("FAIL ldr_state[%0d]: %0d expected %0d", i, StateDbg, exp_st[i]); end
      checks++;
      if (RegW !== (i == 4)) begin errors++; $display("FAIL ldr_regw[%0d]: %b expected %b", i, RegW, (i == 4)); end
      checks++;
      if ({PCS, MemW} !== 2'b00) begin errors++; $display("FAIL ldr_pcs_memw[%0d]: %b expected 00", i, {PCS, MemW}); end
      if (i == 0) begin
        checks++;
        if ({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== 10'b1101_10_10_00) begin
          errors++; $display("FAIL fetch_ctrl: %b expected 1101101000", {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
        end
      end
      if (i == 1) begin
        checks++;
        if ({IRWrite, NextPC, ALUSrcA, ALUSrcB, ImmSrc, RegSrc} !== 9'b001_10_01_10) begin
          errors++; $display("FAIL decode_ctrl: %b expected 001100110", {IRWrite, NextPC, ALUSrcA, ALUSrcB, ImmSrc, RegSrc});
        end
      end
      if (i == 2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl} !== 5'b0_01_00) begin
          errors++; $display("FAIL memadr_ctrl: %b expected 00100", {ALUSrcA, ALUSrcB, ALUControl});
        end
      end
      if (i == 3) begin
        checks++;
        if ({AdrSrc, ResultSrc} !== 3'b1_00) begin errors++; $display("FAIL memread_ctrl: %b expected 100", {AdrSrc, ResultSrc}); end
      end
      if (i == 4) begin
        checks++;
        if (ResultSrc !== 2'b01) begin errors++; $display("FAIL memwb_resultsrc: %b expected 01", ResultSrc); end
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_str();
    logic [3:0] exp_st [5];
    int memw_cycles;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    memw_cycles = 0;
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd15;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (StateDbg !== exp_st[i]) begin errors++; $display("FAIL str_state[%0d]: %0d expected %0d", i, StateDbg, exp_st[i]); end
      checks++;
      if ({RegW, PCS} !== 2'b00) begin errors++; $display("FAIL str_regw_pcs[%0d]: %b expected 00", i, {RegW, PCS}); end
      if (MemW === 1'b1) memw_cycles++;
      if (i == 3) begin
        checks++;
        if ({MemW, AdrSrc} !== 2'b11) begin errors++; $display("FAIL memwrite_ctrl: %b expected 11", {MemW, AdrSrc}); end
      end
      if (i < 4) step();
    end
    checks++;
    if (memw_cycles != 1) begin errors++; $display("FAIL str_memw_count: %0d expected 1", memw_cycles); end
  endtask

  task automatic test_adds_imm();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    Op = 2'b00; Funct = 6'b101001; Rd = 4'd15;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (StateDbg !== exp_st[i]) begin errors++; $display("FAIL adds_state[%0d]: %0d expected %0d", i, StateDbg, exp_st[i]); end
      if (i == 2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl, FlagW, RegW} !== 8'b0_01_00_11_0) begin
          errors++; $display("FAIL adds_executei: %b expected 00100110", {ALUSrcA, ALUSrcB, ALUControl, FlagW, RegW});
        end
      end
      if (i == 3) begin
        checks++;
        if ({RegW, PCS, FlagW, ResultSrc} !== 6'b11_00_00) begin
          errors++; $display("FAIL adds_aluwb: %b expected 110000", {RegW, PCS, FlagW, ResultSrc});
        end
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_cmp_reg();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    Op = 2'b00; Funct = 6'b010101; Rd = 4'd15;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (StateDbg !== exp_st[i]) begin errors++; $display("FAIL cmp_state[%0d]: %0d expected %0d", i, StateDbg, exp_st[i]); end
      if (i == 2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl, FlagW} !== 7'b0_00_01_11) begin
          errors++; $display("FAIL cmp_executer: %b expected 0000111", {ALUSrcA, ALUSrcB, ALUControl, FlagW});
        end
      end
      if (i == 3) begin
        checks++;
        if ({RegW, PCS, FlagW} !== 4'b0000) begin errors++; $display("FAIL cmp_aluwb: %b expected 0000", {RegW, PCS, FlagW}); end
      end
      if (i < 4) step();
    end
  endtask

  // ANDS sets only NZ; undefined cmd decodes as add with no writes at all
  task automatic test_decode_variants();
    Op = 2'b00; Funct = 6'b000001; Rd = 4'd2;
    pulse_reset();
    step(); step();
    checks++;
    if ({StateDbg, ALUControl, FlagW} !== 8'b0110_10_10) begin
      errors++; $display("FAIL ands_execute: %b expected 01101010", {StateDbg, ALUControl, FlagW});
    end
    step();
    checks++;
    if ({StateDbg, RegW, PCS} !== 6'b1000_10) begin errors++; $display("FAIL ands_aluwb: %b expected 100010", {StateDbg, RegW, PCS}); end
    Op = 2'b00; Funct = 6'b000111; Rd = 4'd15;
    pulse_reset();
    step(); step();
    checks++;
    if ({StateDbg, ALUControl, FlagW} !== 8'b0110_00_00) begin
      errors++; $display("FAIL badcmd_execute: %b expected 01100000", {StateDbg, ALUControl, FlagW});
    end
    step();
    checks++;
    if ({StateDbg, RegW, PCS} !== 6'b1000_00) begin errors++; $display("FAIL badcmd_aluwb: %b expected 100000", {StateDbg, RegW, PCS}); end
  endtask

  task automatic test_branch_undef();
    logic [3:0] exp_b [4];
    exp_b = '{4'd0, 4'd1, 4'd9, 4'd0};
    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (StateDbg !== exp_b[i]) begin errors++; $display("FAIL b_state[%0d]: %0d expected %0d", i, StateDbg, exp_b[i]); end
      checks++;
      if ({Branch, PCS} !== {2{i == 2}}) begin errors++; $display("FAIL b_strobes[%0d]: %b expected %b", i, {Branch, PCS}, {2{i == 2}}); end
      if (i == 2) begin
        checks++;
        if ({ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc} !== 11'b0_01_10_00_01_10) begin
          errors++; $display("FAIL branch_ctrl: %b expected 00110000110", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc});
        end
      end
      if (i < 3) step();
    end
    Op = 2'b11; Funct = 6'b111111; Rd = 4'd15;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (StateDbg !== ((i == 1) ? 4'd1 : 4'd0)) begin errors++; $display("FAIL undef_state[%0d]: %0d expected %0d", i, StateDbg, (i == 1)); end
      checks++;
      if ({RegW, MemW, PCS, FlagW, Branch} !== 6'b0) begin
        errors++; $display("FAIL undef_strobes[%0d]: %b expected 000000", i, {RegW, MemW, PCS, FlagW, Branch});
      end
      if (i < 2) step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    Op     = 2'b00;
    Funct  = 6'b0;
    Rd     = 4'd0;
    test_reset();
    @(negedge clk);
    test_ldr();
    test_str();
    test_adds_imm();
    test_cmp_reg();
    test_decode_variants();
    test_branch_undef();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
